// File: rtl/pkt_wr_engine_if.sv
// pkt_wr_engine_if: controller handshake, capture stream and buffer write bus of the packet write engine.
interface pkt_wr_engine_if #(parameter int ADDR_W = 10);
  logic              wr_ctrl;
  logic              wr_ctrl_rdy;
  logic [31:0]       s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_writedata;
  logic              mem_write;
  logic              mem_waitrequest;
  logic [15:0]       pkt_count;
  logic [2:0]        state_out;
  modport slave (
    input  wr_ctrl, s_data, s_valid, s_last, mem_waitrequest,
    output wr_ctrl_rdy, s_ready, mem_address, mem_writedata, mem_write, pkt_count, state_out
  );
  modport master (
    output wr_ctrl, s_data, s_valid, s_last, mem_waitrequest,
    input  wr_ctrl_rdy, s_ready, mem_address, mem_writedata, mem_write, pkt_count, state_out
  );
endinterface

// File: rtl/pkt_wr_engine.sv
// pkt_wr_engine: stores one captured packet (payload, then header) into a circular word buffer.
// Define PKT_WR_TIMESTAMP_EN to add a first-word timestamp as a second header word.
module pkt_wr_engine #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256
) (
  input logic clk,
  input logic reset,
  pkt_wr_engine_if.slave bus
);
`ifdef PKT_WR_TIMESTAMP_EN
  localparam int HDR_WORDS = 2;
`else
  localparam int HDR_WORDS = 1;
`endif
  localparam int IW = $clog2(MAX_WORDS + 1);
  localparam logic [IW-1:0] MAXW = IW'(MAX_WORDS);
  typedef enum logic [2:0] {IDLE = 3'd0, DATA = 3'd1, HDR = 3'd2, TS = 3'd3, DONE = 3'd4} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_buf_ptr, r_addr;
  logic [31:0]       r_data;
  logic              r_write, r_ovf, r_last;
  logic [IW-1:0]     r_idx;
  logic [15:0]       r_pkt_count;
  logic              w_pending, w_wr_done, w_accept, w_ready;
`ifdef PKT_WR_TIMESTAMP_EN
  logic [31:0]       r_ts_cnt, r_ts;
`endif
  assign w_pending = r_write & bus.mem_waitrequest;
  assign w_wr_done = r_write & ~bus.mem_waitrequest;
  assign w_accept  = bus.s_valid & w_ready;
  always_comb begin
    w_next  = r_state;
    w_ready = (r_state == DATA) & ~r_last & ~w_pending;
    case (r_state)
      IDLE:    w_next = bus.wr_ctrl ? DATA : IDLE;
      DATA:    w_next = (r_last & ~w_pending) ? HDR : DATA;
`ifdef PKT_WR_TIMESTAMP_EN
      HDR:     w_next = w_wr_done ? TS : HDR;
`else
      HDR:     w_next = w_wr_done ? DONE : HDR;
`endif
      TS:      w_next = w_wr_done ? DONE : TS;
      DONE:    w_next = bus.wr_ctrl ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_buf_ptr   <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_write     <= 1'b0;
      r_ovf       <= 1'b0;
      r_last      <= 1'b0;
      r_idx       <= '0;
      r_pkt_count <= '0;
    end else begin
      r_write <= w_pending;
      if (r_state == IDLE && bus.wr_ctrl) begin
        r_idx  <= '0;
        r_ovf  <= 1'b0;
        r_last <= 1'b0;
      end
      if (w_accept) begin
        r_last <= bus.s_last;
        if (r_idx < MAXW) begin
          r_write <= 1'b1;
          r_addr  <= r_buf_ptr + ADDR_W'(HDR_WORDS) + ADDR_W'(r_idx);
          r_data  <= bus.s_data;
          r_idx   <= r_idx + 1'b1;
        end else r_ovf <= 1'b1;
      end
      if (r_state == DATA && w_next == HDR) begin
        r_write <= 1'b1;
        r_addr  <= r_buf_ptr;
        r_data  <= {r_ovf, 15'b0, 16'(r_idx)};
      end
`ifdef PKT_WR_TIMESTAMP_EN
      if (r_state == HDR && w_next == TS) begin
        r_write <= 1'b1;
        r_addr  <= r_buf_ptr + ADDR_W'(1);
        r_data  <= r_ts;
      end
`endif
      // commit the packet exactly once, on the edge that enters DONE
      if (r_state != DONE && w_next == DONE) begin
        r_buf_ptr   <= r_buf_ptr + ADDR_W'(HDR_WORDS) + ADDR_W'(r_idx);
        r_pkt_count <= r_pkt_count + 16'd1;
      end
    end
  end
`ifdef PKT_WR_TIMESTAMP_EN
  always_ff @(posedge clk)
    if (!reset) begin
      r_ts_cnt <= '0;
      r_ts     <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 32'd1;
      if (w_accept && r_idx == '0) r_ts <= r_ts_cnt;
    end
`endif
  assign bus.s_ready       = w_ready;
  assign bus.wr_ctrl_rdy   = (r_state == DONE);
  assign bus.mem_address   = r_addr;
  assign bus.mem_writedata = r_data;
  assign bus.mem_write     = r_write;
  assign bus.pkt_count     = r_pkt_count;
  assign bus.state_out     = r_state;
endmodule

// File: doc/pkt_wr_engine.md
PKT_WR_ENGINE -- requirements
Module: pkt_wr_engine

Interface
REQ-001 Parameter ADDR_W, 10, word address width of the capture buffer.
REQ-002 Parameter MAX_WORDS, 256, maximum stored payload words per packet.
REQ-003 clk  input  1  clock; all logic is rising-edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 wr_ctrl  input  1  write request level from the packet controller.
REQ-006 wr_ctrl_rdy  output  1  packet fully stored, header written.
REQ-007 s_data  input  32  capture stream payload word.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_last  input  1  marks the final word of the packet.
REQ-010 s_ready  output  1  engine accepts the word on this cycle.
REQ-011 mem_address  output  ADDR_W  buffer word address.
REQ-012 mem_writedata  output  32  buffer write data.
REQ-013 mem_write  output  1  write strobe; held with address/data until accepted.
REQ-014 mem_waitrequest  input  1  buffer stall; a write completes on a cycle with mem_write=1 and mem_waitrequest=0.
REQ-015 pkt_count  output  16  number of packets stored since reset, wraps at 65535->0.
REQ-016 state_out  output  3  current state encoding for debug.

Function
REQ-017 States: IDLE=0, DATA=1, HDR=2, TS=3, DONE=4; state_out shall equal the encoding.
REQ-018 IDLE: wr_ctrl=1 -> DATA on the next edge; payload index cleared, ovf flag cleared.
REQ-019 s_ready shall be 1 only in DATA and only when no write is pending (mem_write=0 or mem_waitrequest=0).
REQ-020 Each accepted word (s_valid & s_ready) with index < MAX_WORDS shall be written next cycle to buf_ptr + HDR_WORDS + index, modulo 2^ADDR_W.
REQ-021 Accepted words with index >= MAX_WORDS shall be discarded (no mem_write), still accepted, and shall set ovf.
REQ-022 Index shall saturate at MAX_WORDS; the stored length is min(received words, MAX_WORDS).
REQ-023 After the s_last word is accepted and its write (if any) completes -> HDR; no further words accepted.
REQ-024 HDR: write word {ovf, 15'b0, length[15:0]} to buf_ptr; on completion -> TS if timestamping is enabled, else DONE.
REQ-025 DONE: wr_ctrl_rdy=1; buf_ptr += HDR_WORDS + length (mod 2^ADDR_W) and pkt_count += 1 exactly once, on DONE entry.
REQ-026 DONE -> IDLE when wr_ctrl=0; wr_ctrl_rdy stays 1 until then and is 0 in all other states.
REQ-027 Deassertion of wr_ctrl before DONE shall be ignored; the packet still completes.
REQ-028 mem_address/mem_writedata shall not change while mem_write=1 and mem_waitrequest=1.
REQ-029 A one-word packet (s_last on the first word) is legal; a packet cannot have zero words.
REQ-030 The buffer has no read-side pointer; overwriting older packets on wrap is permitted and unflagged.

Reset
REQ-031 reset=0 at a clock edge: state=IDLE, buf_ptr=0, pkt_count=0, mem_write=0, s_ready=0, wr_ctrl_rdy=0, ovf=0, index=0.
REQ-032 Reset mid-packet shall abandon the packet with no header written; the partial payload stays in memory unreferenced.

Configuration
REQ-033 Macro PKT_WR_TIMESTAMP_EN compiles in timestamping: a 32-bit free-running cycle counter (reset to 0) is latched on acceptance of the first word, HDR_WORDS=2, payload starts at buf_ptr+2, and TS writes the latched value to buf_ptr+1.
REQ-034 Without PKT_WR_TIMESTAMP_EN: no counter, HDR_WORDS=1, payload starts at buf_ptr+1, and state TS is unreachable.

Verification
REQ-035 No macro; 3-word packet 0xA0,0xA1,0xA2 with no stalls -> mem[1..3]=A0..A2, mem[0]=0x00000003, wr_ctrl_rdy=1, pkt_count=1, next buf_ptr=4.
REQ-036 mem_waitrequest=1 for 3 cycles on the second write -> address/data held stable, s_ready=0 during the stall, final memory identical to REQ-035.
REQ-037 MAX_WORDS=4, 6-word packet -> 4 words stored, header=0x80000004, all 6 words accepted.
REQ-038 ADDR_W=4, buf_ptr=14, 2-word packet -> header at 14, payload at 15 and 0, next buf_ptr=1.
REQ-039 wr_ctrl held 1 after DONE for 5 cycles -> wr_ctrl_rdy stays 1, pkt_count increments once; reset=0 mid-DATA -> IDLE, pkt_count unchanged.
REQ-040 PKT_WR_TIMESTAMP_EN, first word accepted when the counter reads 0x20 -> mem[1]=0x00000020, payload from mem[2], next buf_ptr=length+2.
